// File: rtl/teclado_pkg.sv
// Shared types and defaults for the keypad sequencing controller.
// Holds the key-code width, default sizes and the FSM state encoding.
package teclado_pkg;

   localparam int CODE_W         = 5;
   localparam int FIFO_DEPTH_DEF = 4;
   localparam int DEBOUNCE_DEF   = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONFIRM = 2'd1,
      HELD    = 2'd2,
      RELEASE = 2'd3
   } state_t;

endpackage

// File: rtl/fifo_teclas.sv
// Small key-code FIFO with registered storage and wrap-around pointers.
// Ports: clk, reset (sync, active-high), push/din, pop, full, empty,
// count (occupancy 0..DEPTH), dout (head code, 0 when empty).
module fifo_teclas #(
   parameter int DEPTH = 4,
   parameter int W     = 5
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             din,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic [W-1:0]             dout
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);

   // A push into a full FIFO is allowed only when the head leaves in
   // the same cycle; the freed slot is then the write slot.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   assign dout = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/control_teclado.sv
// Keypad sequencing controller: gates scanner, debounces press/release,
// queues one code per press. Ports: clk, reset, button_pressed,
// indice_boton, enable_teclado, tecla_valid/codigo/ready, nivel_fifo,
// overflow (sticky drop flag).
module control_teclado #(
   parameter int DEBOUNCE_CYCLES = teclado_pkg::DEBOUNCE_DEF,
   parameter int FIFO_DEPTH      = teclado_pkg::FIFO_DEPTH_DEF,
   parameter int CODE_W          = teclado_pkg::CODE_W
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          button_pressed,
   input  logic [CODE_W-1:0]             indice_boton,
   output logic                          enable_teclado,
   output logic                          tecla_valid,
   output logic [CODE_W-1:0]             tecla_codigo,
   input  logic                          tecla_ready,
   output logic [$clog2(FIFO_DEPTH):0]   nivel_fifo,
   output logic                          overflow
);

   import teclado_pkg::*;

   localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int LW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   state_t              state;
   state_t              state_n;
   logic [CW-1:0]       cnt;
   logic [CW-1:0]       cnt_n;
   logic [CODE_W-1:0]   cand;
   logic [CODE_W-1:0]   cand_n;
   logic                push_key;
   logic                fifo_push;
   logic                fifo_pop;
   logic                full;
   logic                empty;
   logic                ovf;
   logic [LW-1:0]       level;
   logic [CODE_W-1:0]   head;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         cand  <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         cand  <= cand_n;
      end
   end

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      cand_n   = cand;
      push_key = 1'b0;
      unique case (state)
         IDLE: begin
            if (button_pressed) begin
               cand_n  = indice_boton;
               cnt_n   = '0;
               state_n = CONFIRM;
            end
         end
         CONFIRM: begin
            // Any drop or code change restarts from IDLE.
            if (button_pressed && indice_boton == cand) begin
               if (cnt == CNT_LAST) begin
                  push_key = 1'b1;
                  state_n  = HELD;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end else begin
               state_n = IDLE;
            end
         end
         HELD: begin
            if (!button_pressed) begin
               cnt_n   = '0;
               state_n = RELEASE;
            end
         end
         RELEASE: begin
            // A re-press returns to HELD, never to a new push.
            if (button_pressed) begin
               state_n = HELD;
            end else if (cnt == CNT_LAST) begin
               state_n = IDLE;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign fifo_push = push_key && !reset;
   assign fifo_pop  = tecla_valid && tecla_ready;

   fifo_teclas #(
      .DEPTH (FIFO_DEPTH),
      .W     (CODE_W)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (cand),
      .full  (full),
      .empty (empty),
      .count (level),
      .dout  (head)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         ovf <= 1'b0;
      end else if (push_key && full && !fifo_pop) begin
         ovf <= 1'b1;
      end
   end

   // Reset forces every output to its idle value in the same cycle.
   assign enable_teclado = (state == IDLE) && !reset;
   assign tecla_valid    = !empty && !reset;
   assign tecla_codigo   = reset ? '0 : head;
   assign nivel_fifo     = reset ? '0 : level;
   assign overflow       = ovf && !reset;

endmodule
